// File: rtl/shift_sequencer.sv
// Counted shift/rotate sequencer: steps the combinational ALU one bit per cycle for N = masked count.
// Latency N+1 cycles from accept to complete; start is ignored while busy. Optional: SHIFT_SEQ_COUNT_MASK_EN.
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

module shift_sequencer (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [`MC_ALUOp_t_BITS-1:0]   shift_op,
  input  logic                          is_8_bit,
  input  logic [15:0]                   operand,
  input  logic [7:0]                    count,
  input  logic [15:0]                   flags_in,
  output logic [15:0]                   alu_a,
  output logic [15:0]                   alu_b,
  output logic [`MC_ALUOp_t_BITS-1:0]   alu_op,
  output logic                          alu_is_8_bit,
  output logic [15:0]                   alu_flags_in,
  input  logic [15:0]                   alu_out,
  input  logic [15:0]                   alu_flags_out,
  output logic [15:0]                   result,
  output logic [15:0]                   flags_out,
  output logic                          busy,
  output logic                          complete
);

  localparam logic [`MC_ALUOp_t_BITS-1:0] ALUOP_SELA = '0;

`ifdef SHIFT_SEQ_COUNT_MASK_EN
  localparam int RW = 5;
  logic [RW-1:0] masked_count;
  assign masked_count = count[4:0];
`else
  localparam int RW = 8;
  logic [RW-1:0] masked_count;
  assign masked_count = count;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [15:0]                   acc_q, acc_d;
  logic [15:0]                   flag_acc_q, flag_acc_d;
  logic [`MC_ALUOp_t_BITS-1:0]   op_q, op_d;
  logic                          is8_q, is8_d;
  logic [RW-1:0]                 rem_q, rem_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= 16'h0000;
      flag_acc_q <= 16'h0000;
      op_q       <= ALUOP_SELA;
      is8_q      <= 1'b0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      flag_acc_q <= flag_acc_d;
      op_q       <= op_d;
      is8_q      <= is8_d;
      rem_q      <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    flag_acc_d = flag_acc_q;
    op_d       = op_q;
    is8_d      = is8_q;
    rem_d      = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d      = operand;
          flag_acc_d = flags_in;
          op_d       = shift_op;
          is8_d      = is_8_bit;
          rem_d      = masked_count;
          // A zero count skips the ALU entirely so operand and flags pass through untouched.
          state_d    = (masked_count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d      = alu_out;
        flag_acc_d = alu_flags_out;
        rem_d      = rem_q - 1'b1;
        if (rem_q == RW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_a        = acc_q;
  assign alu_b        = (state_q == ST_SHIFT) ? 16'd1 : 16'd0;
  assign alu_op       = (state_q == ST_SHIFT) ? op_q : ALUOP_SELA;
  assign alu_is_8_bit = is8_q;
  assign alu_flags_in = flag_acc_q;
  // Accumulators only change on accept or while shifting, so results hold after DONE.
  assign result       = acc_q;
  assign flags_out    = flag_acc_q;
  assign busy         = (state_q != ST_IDLE);
  assign complete     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-bit shift ALU; CF is flags bit 0.
`timescale 1ns/1ps
module tb_shift_sequencer;

  localparam logic [4:0] OP_SELA = 5'h00;
  localparam logic [4:0] OP_SHL  = 5'h0B;
  localparam logic [4:0] OP_SHR  = 5'h0C;
  localparam logic [4:0] OP_SAR  = 5'h0D;
  localparam logic [4:0] OP_ROL  = 5'h0E;
  localparam logic [4:0] OP_ROR  = 5'h0F;
  localparam logic [4:0] OP_RCL  = 5'h10;
  localparam logic [4:0] OP_RCR  = 5'h11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  shift_op;
  logic        is_8_bit;
  logic [15:0] operand;
  logic [7:0]  count;
  logic [15:0] flags_in;
  logic [15:0] alu_a, alu_b, alu_flags_in, alu_out, alu_flags_out;
  logic [4:0]  alu_op;
  logic        alu_is_8_bit;
  logic [15:0] result, flags_out;
  logic        busy, complete;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op),
    .is_8_bit(is_8_bit), .operand(operand), .count(count), .flags_in(flags_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_8_bit(alu_is_8_bit),
    .alu_flags_in(alu_flags_in), .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .result(result), .flags_out(flags_out), .busy(busy), .complete(complete)
  );

  // Reference ALU: one-bit shift by b (only b==1 is exercised), 8-bit mode returns a zero high byte.
  always_comb begin
    logic [15:0] a;
    logic        cf, ncf, msb;
    logic [15:0] r;
    a   = alu_a;
    cf  = alu_flags_in[0];
    msb = alu_is_8_bit ? a[7] : a[15];
    r   = a;
    ncf = cf;
    case (alu_op)
      OP_SHL: begin r = a << 1; ncf = msb; end
      OP_SHR: begin r = alu_is_8_bit ? {8'h00, a[7:0]} >> 1 : a >> 1; ncf = a[0]; end
      OP_SAR: begin r = alu_is_8_bit ? {8'h00, msb, a[7:1]} : {msb, a[15:1]}; ncf = a[0]; end
      OP_ROL: begin r = alu_is_8_bit ? {8'h00, a[6:0], a[7]} : {a[14:0], a[15]}; ncf = msb; end
      OP_ROR: begin r = alu_is_8_bit ? {8'h00, a[0], a[7:1]} : {a[0], a[15:1]}; ncf = a[0]; end
      OP_RCL: begin r = alu_is_8_bit ? {8'h00, a[6:0], cf} : {a[14:0], cf}; ncf = msb; end
      OP_RCR: begin r = alu_is_8_bit ? {8'h00, cf, a[7:1]} : {cf, a[15:1]}; ncf = a[0]; end
      default: begin r = a; ncf = cf; end
    endcase
    if (alu_is_8_bit) r[15:8] = 8'h00;
    alu_out       = r;
    alu_flags_out = {alu_flags_in[15:1], ncf};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int   lat, busy_cyc;
  logic saw_op;

  // Issues one request and samples each cycle at negedge until complete (bounded).
  task automatic do_op(input logic [4:0] op, input logic is8, input logic [15:0] opnd,
                       input logic [7:0] cnt, input logic [15:0] fl);
    @(negedge clk);
    shift_op = op; is_8_bit = is8; operand = opnd; count = cnt; flags_in = fl;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cyc = 0; saw_op = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      if (alu_op == op) saw_op = 1'b1;
      if (complete) break;
    end
    if (!complete) chk("timeout", 32'(lat), 32'hFFFF_FFFF);
  endtask

  initial begin
    int ncyc, ncomp;
    reset = 1'b1; start = 1'b0; shift_op = OP_SELA; is_8_bit = 1'b0;
    operand = 16'h0; count = 8'h0; flags_in = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_complete", 32'(complete), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'(OP_SELA));
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    reset = 1'b0;

    // SHL 1 by 3
    do_op(OP_SHL, 1'b0, 16'h0001, 8'd3, 16'h0000);
    chk("shl3_lat", 32'(lat), 32'd4);
    chk("shl3_busy", 32'(busy_cyc), 32'd4);
    chk("shl3_result", 32'(result), 32'h0008);
    chk("shl3_cf", 32'(flags_out[0]), 32'd0);
    @(negedge clk);
    chk("shl3_busy_fall", 32'(busy), 32'd0);
    chk("shl3_pulse", 32'(complete), 32'd0);
    chk("shl3_hold", 32'(result), 32'h0008);

    // zero count passes through
    do_op(OP_SHL, 1'b0, 16'hA5A5, 8'd0, 16'h0ACD);
    chk("zero_lat", 32'(lat), 32'd1);
    chk("zero_result", 32'(result), 32'hA5A5);
    chk("zero_flags", 32'(flags_out), 32'h0ACD);
    chk("zero_no_alu", 32'(saw_op), 32'd0);

    // RCL 8-bit
    do_op(OP_RCL, 1'b1, 16'h0080, 8'd1, 16'h0000);
    chk("rcl1_res", 32'(result[7:0]), 32'h00);
    chk("rcl1_cf", 32'(flags_out[0]), 32'd1);
    do_op(OP_RCL, 1'b1, 16'h0080, 8'd2, 16'h0000);
    chk("rcl2_res", 32'(result[7:0]), 32'h01);
    chk("rcl2_cf", 32'(flags_out[0]), 32'd0);

    // SAR and ROL for coverage of sign fill / rotate
    do_op(OP_SAR, 1'b0, 16'h8001, 8'd2, 16'h0000);
    chk("sar2_res", 32'(result), 32'hE000);
    chk("sar2_cf", 32'(flags_out[0]), 32'd0);
    do_op(OP_ROL, 1'b1, 16'h0081, 8'd1, 16'h0000);
    chk("rol8_res", 32'(result[7:0]), 32'h03);
    chk("rol8_cf", 32'(flags_out[0]), 32'd1);

    // count masking
    do_op(OP_SHR, 1'b0, 16'h8000, 8'h21, 16'h0000);
`ifdef SHIFT_SEQ_COUNT_MASK_EN
    chk("cnt33_lat", 32'(lat), 32'd2);
    chk("cnt33_res", 32'(result), 32'h4000);
`else
    chk("cnt33_lat", 32'(lat), 32'd34);
    chk("cnt33_res", 32'(result), 32'h0000);
`endif

    // start pulses while busy are dropped; back-to-back accept after complete
    @(negedge clk);
    shift_op = OP_SHL; is_8_bit = 1'b0; operand = 16'h0003; count = 8'd4; flags_in = 16'h0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ncyc = 0; ncomp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ncyc++;
      if (complete) begin ncomp++; break; end
      start = (ncyc == 1 || ncyc == 2);
    end
    start = 1'b0;
    chk("ign_lat", 32'(ncyc), 32'd5);
    chk("ign_ncomp", 32'(ncomp), 32'd1);
    chk("ign_res", 32'(result), 32'h0030);
    do_op(OP_ROR, 1'b0, 16'h0001, 8'd1, 16'h0000);
    chk("b2b_lat", 32'(lat), 32'd2);
    chk("b2b_res", 32'(result), 32'h8000);
    chk("b2b_cf", 32'(flags_out[0]), 32'd1);
    ncomp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (complete) ncomp++;
    end
    chk("b2b_no_extra", 32'(ncomp), 32'd0);

    // reset mid-operation
    @(negedge clk);
    shift_op = OP_SHL; is_8_bit = 1'b0; operand = 16'h0001; count = 8'd5; flags_in = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_flags", 32'(flags_out), 32'd0);
    chk("mid_rst_complete", 32'(complete), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'(OP_SELA));
    @(negedge clk);
    reset = 1'b0;
    ncomp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (complete || busy) ncomp++;
    end
    chk("post_rst_idle", 32'(ncomp), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that drives the combinational ALU through repeated single-bit shift/rotate operations to implement counted SHL/SHR/SAR/ROL/ROR/RCL/RCR. It sits between the microcode sequencer and the ALU. It latches the operand, count and flags, then owns the ALU's `a`/`b`/`op`/`flags_in` inputs for one cycle per bit position. It accumulates the result and flags, and returns them with a busy/complete handshake.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `shift_op`  in  `MC_ALUOp_t_BITS`  one of ALUOp_SHL/SHR/SAR/ROL/ROR/RCL/RCR; latched on accept.
- `is_8_bit`  in  1  operand width select; latched on accept.
- `operand`  in  16  value to shift; latched on accept.
- `count`  in  8  shift count (CL or immediate); latched on accept after masking.
- `flags_in`  in  16  architectural flags at start; latched on accept.
- `alu_a`  out  16  to ALU `a`; accumulator value.
- `alu_b`  out  16  to ALU `b`; constant 16'd1 while SHIFT, 0 otherwise.
- `alu_op`  out  `MC_ALUOp_t_BITS`  to ALU `op`; latched op while SHIFT, ALUOp_SELA otherwise.
- `alu_is_8_bit`  out  1  latched width.
- `alu_flags_in`  out  16  to ALU `flags_in`; flag accumulator.
- `alu_out`  in  16  ALU `out[15:0]`.
- `alu_flags_out`  in  16  ALU `flags_out`.
- `result`  out  16  final value; valid when `complete`.
- `flags_out`  out  16  final flags; valid when `complete`.
- `busy`  out  1  high in SHIFT and DONE.
- `complete`  out  1  single-cycle pulse in DONE.

Reset values: all outputs 0, except `alu_op` = ALUOp_SELA. State = IDLE, accumulators 0, remaining count 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, `start`=1: latch `operand`→acc, `flags_in`→flag acc, `shift_op`, `is_8_bit`, masked count→`remaining`.
  - Masked count 0 → DONE.
  - Otherwise → SHIFT.
- IDLE, `start`=0: remain IDLE.
- SHIFT, each cycle:
  - ALU driven with (acc, 1, op, flag acc).
  - At the edge: acc←`alu_out`, flag acc←`alu_flags_out`, `remaining`←`remaining`-1.
  - Transition to DONE on the edge where `remaining`==1.
- DONE: `complete`=1, `result`=acc, `flags_out`=flag acc. Next state is IDLE unconditionally.
- Zero count: `result`=operand unchanged, `flags_out`=`flags_in` unchanged. ALU never invoked with the shift op.
- 8-bit mode: the ALU handles width. Acc bits [15:8] carry whatever the ALU returns; the sequencer does not mask them.
- `start` in SHIFT or DONE is ignored and not queued. The requester must wait for `complete`.
- `start` in the IDLE cycle immediately after DONE is accepted normally (back-to-back rate).
- Reset asserted mid-operation: immediate return to IDLE, reset values on all outputs, no `complete`. The partial result is discarded.
- `result`/`flags_out` hold their values after DONE until the next accept.

## Timing
- Accept edge = E0.
- Nonzero masked count N: SHIFT occupies cycles E0..E(N-1), DONE is the cycle after E(N-1), and `complete` is high in cycle N+1 after accept.
- Total latency, start-accept to `complete`, is N+1 cycles. Zero count gives latency 1.
- `busy` rises the cycle after accept and falls the cycle after `complete`.
- ALU path is combinational within one cycle: `alu_*` outputs → ALU → `alu_out`/`alu_flags_out` → registers.

## Configuration
- `SHIFT_SEQ_COUNT_MASK_EN` defined: count masked to `count[4:0]` (80186 semantics). Maximum 31 iterations.
- `SHIFT_SEQ_COUNT_MASK_EN` undefined: full 8-bit count (8086 semantics). Up to 255 iterations, latency up to 256 cycles.
- `remaining` width tracks the mode: 5 bits masked, 8 bits unmasked.

## Test plan
- SHL, 16-bit, operand 0x0001, count 3, flags 0 → `complete` 4 cycles after accept, `result`=0x0008, CF=0; `busy` high exactly 4 cycles.
- Count 0, operand 0xA5A5, flags 0x0ACD → `complete` 1 cycle after accept, `result`=0xA5A5, `flags_out`=0x0ACD; `alu_op` never equals shift op.
- RCL, 8-bit, operand 0x0080, CF=0, count 1 → `result`[7:0]=0x00, CF=1. Then RCL count 2 from 0x0080, CF=0 → `result`[7:0]=0x01, CF=0.
- Count 33 (0x21), SHR, operand 0x8000:
  - With macro: 1 iteration, `result`=0x4000, latency 2.
  - Without macro: 33 iterations, `result`=0x0000, latency 34.
- `start` pulsed at cycles 1 and 2 after accept (count 4) → ignored, exactly one `complete`. `start` held in the cycle after `complete` → second operation accepted.
- `reset` asserted at cycle 2 of a count-5 SHL → `busy`=0, `result`=0, `complete`=0, `alu_op`=ALUOp_SELA immediately. No `complete` after release until a new `start`.
